// File: rtl/conv_line_feeder.sv
// conv_line_feeder
//
// Streaming line buffer that sits directly in front of the convolution
// window register. Pixels arrive one per handshake in row-major order. The
// block keeps the previous K_H-1 rows and, for every accepted pixel, emits
// one K_H-tall column as a single-cycle load pulse on the next cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     input pixel valid
//   in_ready     feeder can accept a pixel (combinational: !stall && !rst)
//   in_data      8-bit unsigned input pixel
//   stall        downstream cannot take a column this cycle
//   out_load_en  one-cycle pulse, out_col is valid
//   out_col      K_H pixels; [0] oldest row, [K_H-1] current row
//   win_valid    this column completes a full K_H x K_W window
//   out_row      row index of the current-row pixel in out_col
//   out_col_idx  column index of out_col
//   frame_done   pulses with the last column of the frame
//
// K_H must be at least 2, IMG_W >= K_W and IMG_H >= K_H.
module conv_line_feeder #(
  parameter int K_H   = 3,
  parameter int K_W   = 3,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic                       stall,
  output logic                       out_load_en,
  output logic [0:K_H-1][7:0]        out_col,
  output logic                       win_valid,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col_idx,
  output logic                       frame_done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] KW_LAST   = CW'(K_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] FILL_LAST = RW'(K_H - 2);

  typedef enum logic {
    FILL,
    STREAM
  } state_e;

  state_e state_q, state_d;

  // line_q[0] holds the oldest stored row, line_q[K_H-2] the most recent one
  logic [7:0] line_q [0:K_H-2][0:IMG_W-1];
  logic [7:0] line_d [0:K_H-2][0:IMG_W-1];

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  logic                load_en_q, load_en_d;
  logic [0:K_H-1][7:0] out_col_q, out_col_d;
  logic                win_valid_q, win_valid_d;
  logic [RW-1:0]       out_row_q, out_row_d;
  logic [CW-1:0]       out_col_idx_q, out_col_idx_d;
  logic                frame_done_q, frame_done_d;

  logic accept;
  logic last_col;
  logic last_row;

  assign in_ready = !stall && !rst;
  assign accept   = in_valid && in_ready;
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  // Next-state logic. Outputs default to a bubble; only an accepted pixel
  // produces a column. Being in STREAM is equivalent to r >= K_H-1, so the
  // state doubles as the row half of the window-valid qualification.
  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    row_d         = row_q;
    col_d         = col_q;
    load_en_d     = 1'b0;
    out_col_d     = out_col_q;
    win_valid_d   = 1'b0;
    out_row_d     = out_row_q;
    out_col_idx_d = out_col_idx_q;
    frame_done_d  = 1'b0;

    if (accept) begin
      load_en_d     = 1'b1;
      out_row_d     = row_q;
      out_col_idx_d = col_q;
      for (int i = 0; i < K_H - 1; i++) begin
        out_col_d[i] = line_q[i][col_q];
      end
      out_col_d[K_H-1] = in_data;
      win_valid_d  = (state_q == STREAM) && (col_q >= KW_LAST);
      frame_done_d = (state_q == STREAM) && last_row && last_col;

      // Each stored row at this column moves one step older
      for (int i = 0; i < K_H - 2; i++) begin
        line_d[i][col_q] = line_q[i+1][col_q];
      end
      line_d[K_H-2][col_q] = in_data;

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      case (state_q)
        FILL: begin
          if (last_col && (row_q == FILL_LAST)) begin
            state_d = STREAM;
          end
        end
        STREAM: begin
          // Wiping the rows here means pixel (0,0) of the next frame,
          // even back-to-back, sees only zeros above it
          if (last_row && last_col) begin
            state_d = FILL;
            for (int i = 0; i < K_H - 1; i++) begin
              for (int j = 0; j < IMG_W; j++) begin
                line_d[i][j] = '0;
              end
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // All state, including the registered outputs, updates here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      line_q        <= '{default: '0};
      row_q         <= '0;
      col_q         <= '0;
      load_en_q     <= 1'b0;
      out_col_q     <= '0;
      win_valid_q   <= 1'b0;
      out_row_q     <= '0;
      out_col_idx_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      row_q         <= row_d;
      col_q         <= col_d;
      load_en_q     <= load_en_d;
      out_col_q     <= out_col_d;
      win_valid_q   <= win_valid_d;
      out_row_q     <= out_row_d;
      out_col_idx_q <= out_col_idx_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign out_load_en = load_en_q;
  assign out_col     = out_col_q;
  assign win_valid   = win_valid_q;
  assign out_row     = out_row_q;
  assign out_col_idx = out_col_idx_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_conv_line_feeder.sv
// tb_conv_line_feeder
//
// Bench for conv_line_feeder with a 3x3 kernel on a 4x4 image. A frame-image
// model records the pixels of the current frame; each accepted pixel pushes
// its expected column onto a scoreboard queue, which is popped whenever the
// DUT raises out_load_en.
module tb_conv_line_feeder;

  localparam int K_H   = 3;
  localparam int K_W   = 3;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;

  logic                      clk;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [7:0]                in_data;
  logic                      stall;
  logic                      out_load_en;
  logic [0:K_H-1][7:0]       out_col;
  logic                      win_valid;
  logic [$clog2(IMG_H)-1:0]  out_row;
  logic [$clog2(IMG_W)-1:0]  out_col_idx;
  logic                      frame_done;

  typedef struct {
    logic [23:0] col;
    int          row;
    int          cidx;
    int          win;
    int          fdone;
  } exp_t;

  exp_t sb[$];

  int check_count = 0;
  int error_count = 0;

  int pix [0:IMG_H-1][0:IMG_W-1];
  int model_r = 0;
  int model_c = 0;

  int load_seen  = 0;
  int win_seen   = 0;
  int fdone_seen = 0;

  conv_line_feeder #(
    .K_H  (K_H),
    .K_W  (K_W),
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .stall      (stall),
    .out_load_en(out_load_en),
    .out_col    (out_col),
    .win_valid  (win_valid),
    .out_row    (out_row),
    .out_col_idx(out_col_idx),
    .frame_done (frame_done)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single point of comparison: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Builds the expected column for pixel (model_r, model_c) from the frame
  // image and advances the row/column position
  task automatic modelAccept(input int data);
    exp_t e;
    int   rr;
    int   v;
    pix[model_r][model_c] = data;
    for (int k = 0; k < K_H; k++) begin
      rr = model_r - (K_H - 1 - k);
      v  = (rr >= 0) ? pix[rr][model_c] : 0;
      e.col[23-8*k -: 8] = v[7:0];
    end
    e.row   = model_r;
    e.cidx  = model_c;
    e.win   = (model_r >= K_H - 1 && model_c >= K_W - 1) ? 1 : 0;
    e.fdone = (model_r == IMG_H - 1 && model_c == IMG_W - 1) ? 1 : 0;
    sb.push_back(e);
    if (model_c == IMG_W - 1) begin
      model_c = 0;
      model_r = (model_r == IMG_H - 1) ? 0 : model_r + 1;
    end else begin
      model_c = model_c + 1;
    end
  endtask

  // One clock cycle of stimulus followed by output checks
  task automatic applyStimulus(input logic valid, input int data, input logic stall_in);
    logic acc;
    exp_t e;
    @(negedge clk);
    in_valid = valid;
    in_data  = data[7:0];
    stall    = stall_in;
    acc      = valid && !stall_in;
    #1;
    checkOutput("in_ready", int'(in_ready), int'(!stall_in));
    if (acc) modelAccept(data);
    @(posedge clk);
    #1;
    checkOutput("load_en", int'(out_load_en), int'(acc));
    if (out_load_en) begin
      load_seen++;
      if (win_valid) win_seen++;
      if (frame_done) fdone_seen++;
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 0, 1);
      end else begin
        e = sb.pop_front();
        checkOutput("out_col", int'({out_col[0], out_col[1], out_col[2]}), int'(e.col));
        checkOutput("out_row", int'(out_row), e.row);
        checkOutput("out_col_idx", int'(out_col_idx), e.cidx);
        checkOutput("win_valid", int'(win_valid), e.win);
        checkOutput("frame_done", int'(frame_done), e.fdone);
      end
    end else begin
      checkOutput("win_idle", int'(win_valid), 0);
      checkOutput("fdone_idle", int'(frame_done), 0);
    end
  endtask

  task automatic streamFrame(input int base);
    for (int p = 0; p < IMG_W * IMG_H; p++) begin
      applyStimulus(1'b1, base + p, 1'b0);
    end
  endtask

  task automatic checkFrameCounts(input string tag, input int loads, input int wins, input int fds);
    checkOutput({tag, "_loads"}, load_seen, loads);
    checkOutput({tag, "_wins"}, win_seen, wins);
    checkOutput({tag, "_fdone"}, fdone_seen, fds);
    load_seen  = 0;
    win_seen   = 0;
    fdone_seen = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_load_en"}, int'(out_load_en), 0);
    checkOutput({tag, "_win"}, int'(win_valid), 0);
    checkOutput({tag, "_fdone"}, int'(frame_done), 0);
    checkOutput({tag, "_col"}, int'({out_col[0], out_col[1], out_col[2]}), 0);
    checkOutput({tag, "_row"}, int'(out_row), 0);
    checkOutput({tag, "_idx"}, int'(out_col_idx), 0);
    checkOutput({tag, "_ready"}, int'(in_ready), 0);
  endtask

  // Main sequence
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    stall    = 1'b0;
    #2;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] frame 1..16, no stall");
    streamFrame(1);
    checkFrameCounts("frame_a", 16, 4, 1);

    $display("[TB] frame 1..16 with 3-cycle stall after pixel 6");
    for (int p = 1; p <= 16; p++) begin
      applyStimulus(1'b1, p, 1'b0);
      if (p == 6) begin
        for (int s = 0; s < 3; s++) applyStimulus(1'b1, 7, 1'b1);
      end
    end
    checkFrameCounts("frame_stall", 16, 4, 1);

    $display("[TB] back-to-back frame 101..116");
    streamFrame(101);
    checkFrameCounts("frame_b2b", 16, 4, 1);

    $display("[TB] reset pulse after pixel 9");
    for (int p = 1; p <= 9; p++) applyStimulus(1'b1, p, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    checkAllZero("mid_reset");
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    model_r = 0;
    model_c = 0;
    sb.delete();
    load_seen  = 0;
    win_seen   = 0;
    fdone_seen = 0;
    streamFrame(50);
    checkFrameCounts("frame_after_rst", 16, 4, 1);

    $display("[TB] frame 1..16 with in_valid gaps");
    for (int p = 1; p <= 16; p++) begin
      applyStimulus(1'b1, p, 1'b0);
      applyStimulus(1'b0, 8'hEE, 1'b0);
    end
    checkFrameCounts("frame_gaps", 16, 4, 1);

    checkOutput("sb_leftover", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
